// File: rtl/ram_sp_be.sv
// ram_sp_be - single-port synchronous RAM with per-byte write enables,
// a sequential clear engine and an optional output pipeline register.
//
// After reset, and on any clr_req taken while idle, the clear engine walks
// every word, one per clock, writing CLEAR_VAL. Accesses are dropped
// while the engine is running.
//
// Optional feature macro: RAM_SP_BE_OUTREG_EN
//   defined     -> one extra register stage on dat_o/rd_valid (read latency 2)
//   not defined -> dat_o/rd_valid come straight from the read register (latency 1)
//
// Parameters:
//   DATA_W    data word width (multiple of BYTE_W)
//   ADDR_W    address width, DEPTH = 1 << ADDR_W
//   BYTE_W    bits per write-enable lane, NBE = DATA_W / BYTE_W
//   CLEAR_VAL value written to every word by the clear engine
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   sel       access request this cycle
//   we        1 = write, 0 = read (qualified by sel)
//   be        byte-lane write enables
//   adr       word address
//   dat_i     write data
//   dat_o     read data, held until the next read completes
//   rd_valid  one-cycle pulse when dat_o carries new read data
//   clr_req   request a full-memory clear (taken only while idle)
//   busy      clear engine active
module ram_sp_be #(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 5,
  parameter int                BYTE_W    = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sel,
  input  logic                       we,
  input  logic [DATA_W/BYTE_W-1:0]   be,
  input  logic [ADDR_W-1:0]          adr,
  input  logic [DATA_W-1:0]          dat_i,
  output logic [DATA_W-1:0]          dat_o,
  output logic                       rd_valid,
  input  logic                       clr_req,
  output logic                       busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NBE   = DATA_W / BYTE_W;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic                rd_accept;
  logic                wr_accept;
  logic                clearing;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   mem_wadr;
  logic [NBE-1:0]      lane_we;
  logic [DATA_W-1:0]   lane_wdata;

  logic [DATA_W-1:0]   rd_data_reg;
  logic                rd_valid_reg;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CLEAR;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    rd_accept  = 1'b0;
    wr_accept  = 1'b0;
    case (state_reg)
      CLEAR: begin
        // ptr wraps to 0 naturally on the edge that clears the last word
        ptr_next = ptr_reg + ADDR_W'(1);
        if (&ptr_reg) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        // An access issued with clr_req still completes on this edge
        rd_accept = sel & ~we;
        wr_accept = sel & we;
        if (clr_req) begin
          state_next = CLEAR;
        end
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  assign clearing = (state_reg == CLEAR);
  // state_reg is a flop, so busy is glitch-free and registered
  assign busy     = clearing;

  // ---------------------------------------------------------------------------
  // Array write port, shared between the clear engine and requester writes
  // ---------------------------------------------------------------------------
  assign mem_wadr = clearing ? ptr_reg : adr;

  for (genvar gi = 0; gi < NBE; gi++) begin : g_lane
    assign lane_we[gi] = clearing | (wr_accept & be[gi]);
    assign lane_wdata[gi*BYTE_W +: BYTE_W] =
      clearing ? CLEAR_VAL[gi*BYTE_W +: BYTE_W] : dat_i[gi*BYTE_W +: BYTE_W];
  end

  // No reset on the array: contents are made deterministic by the clear engine
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBE; i++) begin
      if (lane_we[i]) begin
        mem[mem_wadr][i*BYTE_W +: BYTE_W] <= lane_wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read; data holds until the next accepted read
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_accept;
      if (rd_accept) begin
        rd_data_reg <= mem[adr];
      end
    end
  end

`ifdef RAM_SP_BE_OUTREG_EN
  logic [DATA_W-1:0] dat_pipe_reg;
  logic              rd_valid_pipe_reg;

  // Runs independently of the FSM so a read taken alongside clr_req
  // still drains out while the clear is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_pipe_reg      <= '0;
      rd_valid_pipe_reg <= 1'b0;
    end else begin
      dat_pipe_reg      <= rd_data_reg;
      rd_valid_pipe_reg <= rd_valid_reg;
    end
  end

  assign dat_o    = dat_pipe_reg;
  assign rd_valid = rd_valid_pipe_reg;
`else
  assign dat_o    = rd_data_reg;
  assign rd_valid = rd_valid_reg;
`endif

endmodule

// File: tb/tb_ram_sp_be.sv
// tb_ram_sp_be - directed testbench for ram_sp_be (DATA_W=64, ADDR_W=5).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ram_sp_be;

`ifdef RAM_SP_BE_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [63:0] CV = 64'h5A5A_0F0F_C3C3_1234;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        we;
  logic [7:0]  be;
  logic [4:0]  adr;
  logic [63:0] dat_i;
  logic [63:0] dat_o;
  logic        rd_valid;
  logic        clr_req;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  ram_sp_be #(
    .DATA_W   (64),
    .ADDR_W   (5),
    .BYTE_W   (8),
    .CLEAR_VAL(CV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .we      (we),
    .be      (be),
    .adr     (adr),
    .dat_i   (dat_i),
    .dat_o   (dat_o),
    .rd_valid(rd_valid),
    .clr_req (clr_req),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s : got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s : %h", tag, got);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d, input logic [7:0] b);
    sel = 1'b1; we = 1'b1; adr = a; dat_i = d; be = b;
    tick();
    sel = 1'b0; we = 1'b0; be = '0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [63:0] exp, input string tag);
    sel = 1'b1; we = 1'b0; adr = a;
    tick();
    sel = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      chk({tag, "_early"}, 64'(rd_valid), 64'd0);
      tick();
    end
    chk({tag, "_vld"}, 64'(rd_valid), 64'd1);
    chk({tag, "_dat"}, dat_o, exp);
    tick();
    chk({tag, "_pulse"}, 64'(rd_valid), 64'd0);
  endtask

  // Counts busy cycles (bounded) while hammering the port with dropped
  // reads/writes to address 0; reports any rd_valid seen meanwhile.
  task automatic wait_busy(output int cnt, output int rdv_seen);
    cnt = 0;
    rdv_seen = 0;
    while (busy && cnt < 100) begin
      cnt++;
      sel = 1'b1; we = cnt[0]; adr = 5'd0; dat_i = '1; be = '1;
      tick();
      if (rd_valid) rdv_seen++;
    end
    sel = 1'b0; we = 1'b0; be = '0;
    repeat (LAT) begin
      tick();
      if (rd_valid) rdv_seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog : simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    int          seen;
    logic        ov [4];
    logic [63:0] od [4];

    rst_n = 1'b0; sel = 1'b0; we = 1'b0; be = '0; adr = '0;
    dat_i = '0; clr_req = 1'b0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_dat", dat_o, 64'd0);
    chk("rst_rdv", 64'(rd_valid), 64'd0);

    rst_n = 1'b1;
    wait_busy(cnt, seen);
    chk("init_clr_len", 64'(cnt), 64'd32);
    chk("init_clr_rdv", 64'(seen), 64'd0);

    rd(5'd0,  CV, "rd0_clr");
    rd(5'd17, CV, "rd17_clr");
    rd(5'd31, CV, "rd31_clr");

    // Byte-lane merge
    wr(5'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    wr(5'd5, 64'h11223344_55667788, 8'h0F);
    rd(5'd5, 64'hDEADBEEF_55667788, "rd5_merge");

    // dat_o holds through writes, no rd_valid from writes
    wr(5'd7, 64'h01234567_89ABCDEF, 8'hFF);
    tick();
    chk("hold_dat", dat_o, 64'hDEADBEEF_55667788);
    chk("hold_rdv", 64'(rd_valid), 64'd0);

    // be = 0 is a no-op
    wr(5'd7, 64'hFFFFFFFF_FFFFFFFF, 8'h00);
    rd(5'd7, 64'h01234567_89ABCDEF, "rd7_be0");

    // Back-to-back reads
    sel = 1'b1; we = 1'b0; adr = 5'd5;
    tick(); ov[0] = rd_valid; od[0] = dat_o;
    adr = 5'd7;
    tick(); ov[1] = rd_valid; od[1] = dat_o;
    sel = 1'b0;
    tick(); ov[2] = rd_valid; od[2] = dat_o;
    tick(); ov[3] = rd_valid; od[3] = dat_o;
    chk("b2b_vld_a", 64'(ov[LAT-1]), 64'd1);
    chk("b2b_dat_a", od[LAT-1], 64'hDEADBEEF_55667788);
    chk("b2b_vld_b", 64'(ov[LAT]), 64'd1);
    chk("b2b_dat_b", od[LAT], 64'h01234567_89ABCDEF);
    chk("b2b_end", 64'(ov[LAT+1]), 64'd0);

    // clr_req together with a write to address 3
    chk("pre_clr_busy", 64'(busy), 64'd0);
    sel = 1'b1; we = 1'b1; adr = 5'd3; dat_i = {8{8'hAA}}; be = 8'hFF;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0; sel = 1'b0; we = 1'b0; be = '0;
    chk("clr_busy_rise", 64'(busy), 64'd1);
    wait_busy(cnt, seen);
    chk("clr_len", 64'(cnt), 64'd32);
    chk("clr_rdv", 64'(seen), 64'd0);
    rd(5'd3, CV, "rd3_clr");
    rd(5'd0, CV, "rd0_dropped");
    rd(5'd5, CV, "rd5_clr");

    // Read accepted with clr_req still emerges; dat_o holds during clear
    wr(5'd7, 64'h01234567_89ABCDEF, 8'hFF);
    sel = 1'b1; we = 1'b0; adr = 5'd7; clr_req = 1'b1;
    tick();
    sel = 1'b0; clr_req = 1'b0;
    for (int i = 1; i < LAT; i++) tick();
    chk("clrrd_vld", 64'(rd_valid), 64'd1);
    chk("clrrd_dat", dat_o, 64'h01234567_89ABCDEF);
    wait_busy(cnt, seen);
    chk("clrrd_rdv_after", 64'(seen), 64'd0);
    chk("clrrd_hold", dat_o, 64'h01234567_89ABCDEF);

    // Reset in the middle of a clear at ptr = 20
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (20) tick();
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_dat", dat_o, 64'd0);
    chk("midrst_rdv", 64'(rd_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd1);
    #1;
    rst_n = 1'b1;
    wait_busy(cnt, seen);
    chk("midrst_clr_len", 64'(cnt), 64'd32);
    chk("midrst_rdv_seen", 64'(seen), 64'd0);
    rd(5'd7,  CV, "rd7_after_rst");
    rd(5'd31, CV, "rd31_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ram_sp_be.md
# ram_sp_be

Parametrised single-port synchronous RAM with per-byte write enables, a built-in sequential clear engine and an optional output pipeline register. It is the next-generation general memory primitive for the memory integration suite: arbitrary data width and depth, deterministic contents after reset without an `initial` loop, and a software-triggerable re-clear. It sits behind a single requester that drives `sel`/`we` one access per cycle.

## Interface
- `DATA_W`, 64, data word width; must be a multiple of `BYTE_W`
- `ADDR_W`, 5, address width; depth `DEPTH = 1 << ADDR_W`
- `BYTE_W`, 8, bits per write-enable lane; `NBE = DATA_W / BYTE_W`
- `CLEAR_VAL`, 0, `DATA_W`-bit value written to every word by the clear engine

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `sel`  in  1  access request this cycle
- `we`  in  1  1 = write, 0 = read (qualified by `sel`)
- `be`  in  NBE  byte-lane write enables (writes only)
- `adr`  in  ADDR_W  word address
- `dat_i`  in  DATA_W  write data
- `dat_o`  out  DATA_W  read data, held until next read completes
- `rd_valid`  out  1  one-cycle pulse when `dat_o` carries new read data
- `clr_req`  in  1  request a full-memory clear (sampled in IDLE only)
- `busy`  out  1  clear engine active; accesses are dropped

## Operation
- States: CLEAR, IDLE. Clear pointer `ptr` is `ADDR_W` bits.
- Reset (`rst_n` low, asynchronous): state = CLEAR, `ptr` = 0, `dat_o` = 0, `rd_valid` = 0, `busy` = 1; pipeline register (if built) = 0. Memory array is not reset directly.
- CLEAR: each edge writes `CLEAR_VAL` to `mem[ptr]` and increments `ptr`; on the edge writing `ptr = DEPTH-1`, go to IDLE, `ptr` wraps to 0. All `DEPTH` words are cleared, including the last.
- In CLEAR, `sel`, `we`, `be`, `clr_req` are ignored; no access is queued. `dat_o` holds.
- IDLE read (`sel & ~we`): `dat_o <= mem[adr]` at the edge; `rd_valid` = 1 for the following cycle.
- IDLE write (`sel & we`): for each lane i with `be[i]` = 1, `mem[adr][i*BYTE_W +: BYTE_W] <= dat_i[...]`; lanes with `be[i]` = 0 keep their old value; `be` = 0 is a legal no-op. Writes do not change `dat_o` and do not pulse `rd_valid`.
- `clr_req` in IDLE: state -> CLEAR at that edge. If `sel` is also high the same cycle, that access completes normally at that edge; the clear begins at the next edge.
- Reset asserted mid-clear restarts the clear from address 0.

## Timing
- Read latency: 1 cycle (request edge -> `dat_o` valid); 2 cycles with the output register.
- Throughput: one access per cycle in IDLE; back-to-back reads give back-to-back `rd_valid` pulses.
- Clear duration: exactly `DEPTH` edges. After `rst_n` rises, `busy` is high through edge `DEPTH` and low in the cycle after.
- `busy` is registered and equals (state == CLEAR).
- Read-during-clear is impossible (dropped); read of a cleared word returns `CLEAR_VAL`.

## Configuration
- `RAM_SP_BE_OUTREG_EN` defined: adds one register stage on `dat_o` and `rd_valid` (reset to 0). Read latency becomes 2. A read accepted on the cycle `clr_req` is taken still emerges from the pipeline normally.
- Not defined: `dat_o`/`rd_valid` driven directly from the array read register; latency 1.

## Test plan
- Reset release, `DEPTH` = 32 -> `busy` high for 32 cycles, then low; reads of addresses 0, 17 and 31 return `CLEAR_VAL`, each with one `rd_valid` pulse.
- Write 0xDEADBEEF_CAFEF00D to address 5 with `be` = 0xFF, then write 0x11223344_55667788 with `be` = 0x0F -> read of address 5 returns 0xDEADBEEF_55667788.
- Read address 5 -> `dat_o` updates after 1 edge (2 edges with `RAM_SP_BE_OUTREG_EN`); `rd_valid` pulses exactly one cycle; `dat_o` holds through subsequent writes.
- `clr_req` together with a write of 0xAA..AA to address 3 -> `busy` rises next cycle for 32 cycles; afterwards address 3 reads `CLEAR_VAL`; `sel` pulses driven during `busy` produce no `rd_valid` and no write.
- `rst_n` pulsed low during a clear at `ptr` = 20 -> `dat_o` = 0, `rd_valid` = 0 immediately; the clear restarts and `busy` lasts a full 32 cycles.
- `be` = 0 write to address 7 holding 0x0123456789ABCDEF -> read returns 0x0123456789ABCDEF unchanged.
